// File: rtl/aes_128_sched.sv
// Round-robin front end for the free-running, non-stallable aes_128 pipeline.
// Issue credits cover jobs in flight plus buffered results, so the result FIFO can never overflow.
module aes_128_sched #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [127:0] req1_key,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         resp_id,
    output logic         idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CREDIT_MAX = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] ONE        = (PW+1)'(1);

    logic [PW:0]          credit_q, credit_d;
    logic                 last_grant_q;
    logic [127:0]         core_state_q, core_key_q;
    logic [LATENCY:0]     trk_v_q, trk_id_q;
    logic [PW:0]          wr_ptr_q, rd_ptr_q;
    logic [127:0]         fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_id_q;

    logic can_issue, grant0, grant1, grant_any;
    logic fifo_empty, fifo_push, fifo_pop;

    assign can_issue = (credit_q < CREDIT_MAX) && !rst;
    // On contention the requester that did not win last time gets the slot.
    assign grant0    = can_issue && req0_valid && (!req1_valid || last_grant_q);
    assign grant1    = can_issue && req1_valid && (!req0_valid || !last_grant_q);
    assign grant_any = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign core_state = core_state_q;
    assign core_key   = core_key_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_push  = trk_v_q[LATENCY];
    assign fifo_pop   = resp_valid && resp_ready;
    assign resp_valid = !fifo_empty;
    assign resp_data  = fifo_data_q[rd_ptr_q[PW-1:0]];
    assign resp_id    = fifo_id_q[rd_ptr_q[PW-1:0]];
    assign idle       = (credit_q == '0);

    always_comb begin
        credit_d = credit_q;
        case ({grant_any, fifo_pop})
            2'b10:   credit_d = credit_q + ONE;
            2'b01:   credit_d = credit_q - ONE;
            default: credit_d = credit_q;
        endcase
    end

    // The tracking tap at stage LATENCY lines up with core_out for the job it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q     <= '0;
            last_grant_q <= 1'b1;
            core_state_q <= '0;
            core_key_q   <= '0;
            trk_v_q      <= '0;
            trk_id_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            credit_q <= credit_d;
            if (grant_any) begin
                last_grant_q <= grant1;
                core_state_q <= grant1 ? req1_state : req0_state;
                core_key_q   <= grant1 ? req1_key   : req0_key;
            end
            trk_v_q  <= {trk_v_q[LATENCY-1:0], grant_any};
            trk_id_q <= {trk_id_q[LATENCY-1:0], grant1};
            if (fifo_push) wr_ptr_q <= wr_ptr_q + ONE;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q[PW-1:0]] <= core_out;
            fifo_id_q[wr_ptr_q[PW-1:0]]   <= trk_id_q[LATENCY];
        end
    end
endmodule

// File: tb/tb_aes_128_sched.sv
// Scoreboard bench for aes_128_sched with a behavioural AES-128 core pipeline model.
module tb_aes_128_sched;
    localparam int LAT   = 21;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_state, req0_key, req1_state, req1_key;
    logic [127:0] core_state, core_key, core_out;
    logic         resp_valid, resp_ready, resp_id, idle;
    logic [127:0] resp_data;

    aes_128_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state), .req1_key(req1_key),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .idle(idle)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct { logic [127:0] data; logic id; } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [7:0] sbox [256];
    int nTests = 0, nFail = 0, cyc = 0;
    logic lastG = 1'b1;
    logic acc0, acc1, expR0, expR1, rdy0, rdy1, popped, popId, idleSeen, rvSeen;
    logic [127:0] popData;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  w3, tmp;
        rk = key; rc = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = sbox[s[4*((c+rr)%4)+rr]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            w3  = rk[31:0];
            tmp = {sbox[w3[23:16]] ^ rc, sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
            rk[127:96] = rk[127:96] ^ tmp;
            rk[95:64]  = rk[95:64]  ^ rk[127:96];
            rk[63:32]  = rk[63:32]  ^ rk[95:64];
            rk[31:0]   = rk[31:0]   ^ rk[63:32];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural core: a value on core_state/core_key appears on core_out LAT cycles later.
    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= aes_enc(core_state, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    // One clock: observe handshakes mid-cycle, push accepted jobs, then step past the edge.
    task automatic tick();
        logic canI;
        @(negedge clk);
        canI  = !rst && (sb.size() < DEPTH);
        expR0 = canI && req0_valid && (!req1_valid || lastG);
        expR1 = canI && req1_valid && (!req0_valid || !lastG);
        rdy0 = req0_ready; rdy1 = req1_ready;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin e.data = aes_enc(req0_state, req0_key); e.id = 1'b0; sb.push_back(e); end
        if (acc1) begin e.data = aes_enc(req1_state, req1_key); e.id = 1'b1; sb.push_back(e); end
        if (rst) lastG = 1'b1;
        else if (expR0) lastG = 1'b0;
        else if (expR1) lastG = 1'b1;
        rvSeen = resp_valid; popped = resp_valid && resp_ready;
        popData = resp_data; popId = resp_id; idleSeen = idle;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_state = '0; req0_key = '0; req1_state = '0; req1_key = '0;
        tick(); tick();
        nTests++;
        if ({rvSeen, idleSeen} !== 2'b01) begin nFail++; $display("[TB] FAIL reset_flags: resp_valid,idle=%b expected 01", {rvSeen, idleSeen}); end
        nTests++;
        if ({core_state, core_key} !== 256'h0) begin nFail++; $display("[TB] FAIL reset_core: state=%h key=%h expected 0", core_state, core_key); end
        req0_valid = 1'b1;
        tick();
        nTests++;
        if ({rdy0, rdy1} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_ready: got %b expected 00", {rdy0, rdy1}); end
        req0_valid = 1'b0; rst = 1'b0; sb.delete();
        tick();
    endtask

    task automatic test_fips();
        int start, lat;
        logic got;
        resp_ready = 1'b1; req0_valid = 1'b1; req0_state = FIPS_PT; req0_key = FIPS_KEY;
        tick();
        start = cyc - 1; req0_valid = 1'b0;
        nTests++;
        if (acc0 !== 1'b1) begin nFail++; $display("[TB] FAIL fips_accept: ready0=%b expected 1", rdy0); end
        nTests++;
        if ({core_state, core_key} !== {FIPS_PT, FIPS_KEY}) begin nFail++; $display("[TB] FAIL fips_core_in: state=%h key=%h", core_state, core_key); end
        got = 1'b0; lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (popped) begin
                got = 1'b1; lat = cyc - 1 - start;
                if (sb.size() != 0) void'(sb.pop_front());
                nTests++;
                if ({popId, popData} !== {1'b0, FIPS_CT}) begin nFail++; $display("[TB] FAIL fips_data: got id=%0d data=%h expected id=0 data=%h", popId, popData, FIPS_CT); end
            end
        end
        nTests++;
        if (!got || lat != LAT + 2) begin nFail++; $display("[TB] FAIL fips_latency: got=%b latency=%0d expected %0d", got, lat, LAT + 2); end
        tick();
        nTests++;
        if (idleSeen !== 1'b1) begin nFail++; $display("[TB] FAIL fips_idle: idle=%b expected 1", idleSeen); end
    endtask

    task automatic test_contention();
        int n0 = 0, n1 = 0;
        logic prevId = 1'b0, havePrev = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            req0_valid = (i < 60); req1_valid = (i < 60);
            req0_state = rand128(); req0_key = rand128(); req1_state = rand128(); req1_key = rand128();
            tick();
            nTests++;
            if ({rdy0, rdy1} !== {expR0, expR1}) begin nFail++; $display("[TB] FAIL contention_ready: got %b expected %b cycle %0d", {rdy0, rdy1}, {expR0, expR1}, cyc); end
            if (acc0 || acc1) begin
                if (havePrev) begin
                    nTests++;
                    if (acc1 === prevId) begin nFail++; $display("[TB] FAIL contention_alternate: grant %0d repeated expected %0d", acc1, !prevId); end
                end
                prevId = acc1; havePrev = 1'b1;
                if (acc0) n0++; else n1++;
            end
            if (popped) begin
                nTests++;
                if (sb.size() == 0) begin nFail++; $display("[TB] FAIL contention_pop: unexpected id=%0d data=%h", popId, popData); end
                else begin
                    e = sb.pop_front();
                    if ({popId, popData} !== {e.id, e.data}) begin nFail++; $display("[TB] FAIL contention_pop: got id=%0d data=%h expected id=%0d data=%h", popId, popData, e.id, e.data); end
                end
            end
        end
        nTests++;
        if (n0 == 0 || n1 == 0 || sb.size() != 0) begin nFail++; $display("[TB] FAIL contention_served: n0=%0d n1=%0d left=%0d expected both >0, 0 left", n0, n1, sb.size()); end
    endtask

    task automatic test_backpressure();
        int nAcc = 0;
        logic [127:0] head = '0;
        logic haveHead = 1'b0;
        resp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            req0_state = rand128(); req0_key = rand128(); req1_state = rand128(); req1_key = rand128();
            tick();
            nAcc += int'(acc0) + int'(acc1);
            nTests++;
            if ({rdy0, rdy1} !== {expR0, expR1}) begin nFail++; $display("[TB] FAIL bp_ready: got %b expected %b cycle %0d", {rdy0, rdy1}, {expR0, expR1}, cyc); end
            if (rvSeen && !haveHead) begin head = popData; haveHead = 1'b1; end
            else if (rvSeen) begin
                nTests++;
                if (popData !== head) begin nFail++; $display("[TB] FAIL bp_head_stable: got %h expected %h", popData, head); end
            end
        end
        nTests++;
        if (nAcc != DEPTH || rvSeen !== 1'b1) begin nFail++; $display("[TB] FAIL bp_fill: accepts=%0d resp_valid=%b expected %0d and 1", nAcc, rvSeen, DEPTH); end
        resp_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            tick();
            if (i == 0) begin
                nTests++;
                if ({popped, acc0 || acc1} !== 2'b10) begin nFail++; $display("[TB] FAIL bp_first_pop: pop,accept=%b expected 10", {popped, acc0 || acc1}); end
            end
            if (i == 1) begin
                nTests++;
                if ((acc0 || acc1) !== 1'b1) begin nFail++; $display("[TB] FAIL bp_reissue: accept=%b expected 1", acc0 || acc1); end
            end
            nTests++;
            if ({rdy0, rdy1} !== {expR0, expR1}) begin nFail++; $display("[TB] FAIL bp_ready: got %b expected %b cycle %0d", {rdy0, rdy1}, {expR0, expR1}, cyc); end
            if (popped) begin
                nTests++;
                if (sb.size() == 0) begin nFail++; $display("[TB] FAIL bp_pop: unexpected id=%0d data=%h", popId, popData); end
                else begin
                    e = sb.pop_front();
                    if ({popId, popData} !== {e.id, e.data}) begin nFail++; $display("[TB] FAIL bp_pop: got id=%0d data=%h expected id=%0d data=%h", popId, popData, e.id, e.data); end
                end
            end
        end
        nTests++;
        if (sb.size() != 0) begin nFail++; $display("[TB] FAIL bp_drain: %0d responses missing expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic got = 1'b0;
        resp_ready = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_state = rand128(); req0_key = rand128();
            tick();
        end
        req0_valid = 1'b0;
        nTests++;
        if (sb.size() != 3) begin nFail++; $display("[TB] FAIL rstmid_issue: in flight=%0d expected 3", sb.size()); end
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0; sb.delete();
        for (int i = 0; i < 30; i++) begin
            tick();
            nTests++;
            if ({rvSeen, idleSeen} !== 2'b01) begin nFail++; $display("[TB] FAIL rstmid_quiet: resp_valid,idle=%b expected 01 cycle %0d", {rvSeen, idleSeen}, cyc); end
        end
        req1_valid = 1'b1; req1_state = FIPS_PT; req1_key = FIPS_KEY;
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (popped) begin
                got = 1'b1;
                if (sb.size() != 0) void'(sb.pop_front());
                nTests++;
                if ({popId, popData} !== {1'b1, FIPS_CT}) begin nFail++; $display("[TB] FAIL rstmid_job: got id=%0d data=%h expected id=1 data=%h", popId, popData, FIPS_CT); end
            end
        end
        nTests++;
        if (!got) begin nFail++; $display("[TB] FAIL rstmid_timeout: response=0 expected 1"); end
    endtask

    task automatic test_soak();
        int wait0 = 0, wait1 = 0, n0 = 0, n1 = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!req0_valid || acc0) begin req0_valid = ($urandom_range(9) < 6); req0_state = rand128(); req0_key = rand128(); end
            if (!req1_valid || acc1) begin req1_valid = ($urandom_range(9) < 6); req1_state = rand128(); req1_key = rand128(); end
            resp_ready = ($urandom_range(9) < 7);
            tick();
            nTests++;
            if ({rdy0, rdy1} !== {expR0, expR1} || sb.size() > DEPTH) begin nFail++; $display("[TB] FAIL soak_ready: got %b expected %b outstanding=%0d cycle %0d", {rdy0, rdy1}, {expR0, expR1}, sb.size(), cyc); end
            if (acc0) begin n0++; wait0 = 0; end else if (req0_valid && acc1) wait0++;
            if (acc1) begin n1++; wait1 = 0; end else if (req1_valid && acc0) wait1++;
            if (wait0 > 1 || wait1 > 1) begin
                nTests++; nFail++;
                $display("[TB] FAIL soak_starve: lost opportunities req0=%0d req1=%0d expected <=1", wait0, wait1);
                wait0 = 0; wait1 = 0;
            end
            if (popped) begin
                nTests++;
                if (sb.size() == 0) begin nFail++; $display("[TB] FAIL soak_pop: unexpected id=%0d data=%h", popId, popData); end
                else begin
                    e = sb.pop_front();
                    if ({popId, popData} !== {e.id, e.data}) begin nFail++; $display("[TB] FAIL soak_pop: got id=%0d data=%h expected id=%0d data=%h", popId, popData, e.id, e.data); end
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            tick();
            if (popped && sb.size() != 0) begin
                e = sb.pop_front();
                nTests++;
                if ({popId, popData} !== {e.id, e.data}) begin nFail++; $display("[TB] FAIL soak_drain: got id=%0d data=%h expected id=%0d data=%h", popId, popData, e.id, e.data); end
            end
        end
        tick();
        nTests++;
        if (sb.size() != 0 || idleSeen !== 1'b1 || n0 == 0 || n1 == 0) begin nFail++; $display("[TB] FAIL soak_end: left=%0d idle=%b n0=%0d n1=%0d expected 0,1,>0,>0", sb.size(), idleSeen, n0, n1); end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        test_reset();
        test_fips();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
